reg_bus_master: RTL

Initiator for the register-access bus. It takes one register read or write request at a time from a host-side valid/ready interface and drives a single-cycle select strobe onto the bus. It then waits for the OR-combined acknowledge from the per-port register decoders and returns read data, or a timeout error, on a valid/ready response channel. It sits between the switch's configuration host logic and the NUM_OF_PORTS register decoders.

---
 rtl/reg_bus_pkg.sv | 14 +
 rtl/reg_bus_master.sv | 127 ++++++++++++
 2 files changed

// File: rtl/reg_bus_pkg.sv
// Shared types and defaults for the register-access bus (master and decoders).
package reg_bus_pkg;

  localparam int REG_BUS_W_WIDTH      = 8;
  localparam int REG_BUS_TIMEOUT_DFLT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/reg_bus_master.sv
// Register-bus initiator: one host request at a time, single-cycle select strobe,
// waits for the OR-combined decoder ack or a timeout, then returns a response.
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int W_WIDTH = REG_BUS_W_WIDTH,
  parameter int TIMEOUT = REG_BUS_TIMEOUT_DFLT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_wr,
  input  logic [W_WIDTH-1:0] req_addr,
  input  logic [W_WIDTH-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [W_WIDTH-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               sel_en,
  output logic               wr_rd_s,
  output logic [W_WIDTH-1:0] addr,
  output logic [W_WIDTH-1:0] wr_data,
  input  logic               ack,
  input  logic [W_WIDTH-1:0] rd_data,
  output logic               busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 req_ready_r;
  logic                 sel_en_r;
  logic                 wr_rd_r;
  logic [W_WIDTH-1:0]   addr_r;
  logic [W_WIDTH-1:0]   wr_data_r;
  logic                 rsp_valid_r;
  logic [W_WIDTH-1:0]   rsp_rdata_r;
  logic                 rsp_err_r;
  logic                 busy_r;

  // Transaction FSM with all host- and bus-side outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      req_ready_r <= 1'b1;
      sel_en_r    <= 1'b0;
      wr_rd_r     <= 1'b0;
      addr_r      <= {W_WIDTH{1'b0}};
      wr_data_r   <= {W_WIDTH{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {W_WIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            wr_rd_r     <= req_wr;
            addr_r      <= req_addr;
            wr_data_r   <= req_wdata;
            sel_en_r    <= 1'b1;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= STROBE;
          end
        end
        STROBE: begin
          sel_en_r <= 1'b0;
          cnt_r    <= {CNT_W{1'b0}};
          state_r  <= WAIT;
        end
        WAIT: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (ack) begin
            rsp_rdata_r <= wr_rd_r ? {W_WIDTH{1'b0}} : rd_data;
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else if (cnt_r == CNT_LAST) begin
            rsp_rdata_r <= {W_WIDTH{1'b0}};
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {W_WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
            wr_rd_r     <= 1'b0;
            addr_r      <= {W_WIDTH{1'b0}};
            wr_data_r   <= {W_WIDTH{1'b0}};
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          sel_en_r    <= 1'b0;
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign sel_en    = sel_en_r;
  assign wr_rd_s   = wr_rd_r;
  assign addr      = addr_r;
  assign wr_data   = wr_data_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign busy      = busy_r;

endmodule
